// File: rtl/router_1x3.sv
// router_1x3: byte-serial packet router steering packets by header address into
// three independently read output FIFOs, with parity check and per-FIFO read timeout.
module router_1x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enb_0,
  input  logic                  read_enb_1,
  input  logic                  read_enb_2,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic                  vld_out_0,
  output logic                  vld_out_1,
  output logic                  vld_out_2,
  output logic                  busy,
  output logic                  err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {DA, LFD, LD, FFS, LAF, WTE, CPE, DISCARD} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] hdr, hold, par, pkt_par, wdata;
  logic [1:0] tgt;
  logic hold_is_par, wr;
  logic [2:0] rd_en, empty, full, we;
  assign rd_en = {read_enb_2, read_enb_1, read_enb_0};
  assign busy = !(state inside {DA, LD, DISCARD});
  assign wr = state == LFD || state == LAF || (state == LD && !full[tgt]);
  assign wdata = state == LFD ? hdr : state == LAF ? hold : data_in;
  assign we = wr ? (3'b001 << tgt) : 3'b000;
  always_ff @(posedge clock) begin
    if (resetn) begin
      state <= DA;
      err <= 1'b0;
      hdr <= '0;
      hold <= '0;
      par <= '0;
      pkt_par <= '0;
      tgt <= '0;
      hold_is_par <= 1'b0;
    end else begin
      case (state)
        DA: if (pkt_valid) begin
          if (data_in[1:0] == 2'd3) state <= DISCARD;
          else begin
            hdr <= data_in;
            tgt <= data_in[1:0];
            err <= 1'b0;
            state <= empty[data_in[1:0]] ? LFD : WTE;
          end
        end
        WTE: if (empty[tgt]) state <= LFD;
        LFD: begin
          par <= hdr;
          state <= LD;
        end
        LD: begin
          if (!pkt_valid) pkt_par <= data_in;
          if (full[tgt]) begin
            hold <= data_in;
            hold_is_par <= !pkt_valid;
            state <= FFS;
          end else if (pkt_valid) par <= par ^ data_in;
          else state <= CPE;
        end
        FFS: if (!full[tgt]) state <= LAF;
        LAF: begin
          if (!hold_is_par) par <= par ^ hold;
          state <= hold_is_par ? CPE : LD;
        end
        CPE: begin
          err <= par != pkt_par;
          state <= DA;
        end
        DISCARD: if (!pkt_valid) state <= DA;
        default: state <= DA;
      endcase
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_fifo
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q;
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic w, re, idle, flush;
    assign empty[i] = cnt == '0;
    assign full[i] = cnt == CW'(FIFO_DEPTH);
    assign w = we[i] && !full[i];
    assign re = rd_en[i] && !empty[i];
    assign idle = !empty[i] && !rd_en[i];
    // the increment that would reach TIMEOUT performs the flush instead
    assign flush = idle && tcnt == TW'(TIMEOUT - 1);
    always_ff @(posedge clock) begin
      if (resetn || flush) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        tcnt <= '0;
        q <= '0;
      end else begin
        if (w) mem[wp] <= wdata;
        if (w) wp <= wp + 1'b1;
        if (re) q <= mem[rp];
        if (re) rp <= rp + 1'b1;
        cnt <= cnt + CW'(w) - CW'(re);
        tcnt <= idle ? tcnt + 1'b1 : '0;
      end
    end
  end
  assign data_out_0 = g_fifo[0].q;
  assign data_out_1 = g_fifo[1].q;
  assign data_out_2 = g_fifo[2].q;
  assign vld_out_0 = !empty[0];
  assign vld_out_1 = !empty[1];
  assign vld_out_2 = !empty[2];
endmodule

// File: tb/tb_router_1x3.sv
// tb_router_1x3: packet-level queue model per output, table of packets, directed
// corner sequences and a randomized packet/read phase.
module tb_router_1x3;
  typedef struct {
    logic [7:0] hdr;
    int npay;
    bit bad;
    bit exp_err;
    logic [2:0] exp_vld;
  } vec_t;
  logic clock = 0, resetn = 1, pkt_valid = 0;
  logic [7:0] data_in = 0;
  logic [2:0] rd = 0;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic vld_out_0, vld_out_1, vld_out_2, busy, err;
  logic [7:0] dout [3];
  logic [2:0] vld;
  int checks = 0, errors = 0, busy_cnt = 0, vcnt = 0;
  int mode [3] = '{0, 0, 0};
  int nreads [3] = '{0, 0, 0};
  bit pend [3] = '{0, 0, 0};
  bit model_err = 0;
  logic [7:0] q0[$], q1[$], q2[$];
  vec_t tbl [8];
  assign dout[0] = data_out_0;
  assign dout[1] = data_out_1;
  assign dout[2] = data_out_2;
  assign vld = {vld_out_2, vld_out_1, vld_out_0};
  always #5 clock = ~clock;
  router_1x3 dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb_0(rd[0]), .read_enb_1(rd[1]), .read_enb_2(rd[2]),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .busy(busy), .err(err)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask
  task automatic qpush(input int k, input logic [7:0] b);
    case (k)
      0: q0.push_back(b);
      1: q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask
  task automatic qpop(input int k, output logic [7:0] b);
    case (k)
      0: b = q0.pop_front();
      1: b = q1.pop_front();
      default: b = q2.pop_front();
    endcase
  endtask
  function automatic int qsize(input int k);
    return k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
  endfunction
  // read driver and scoreboard: every performed read must return the model's next byte
  always @(negedge clock) begin : mon
    logic [7:0] b;
    for (int k = 0; k < 3; k++) begin
      if (pend[k]) begin
        nreads[k]++;
        if (qsize(k) == 0) begin
          checks++;
          errors++;
          $display("FAIL rd%0d_extra: got 0x%0h, want no data", k, dout[k]);
        end else begin
          qpop(k, b);
          check($sformatf("rd%0d_data", k), dout[k], b);
        end
      end
      rd[k] = mode[k] == 1 || (mode[k] == 2 && $urandom_range(3) != 0);
      pend[k] = rd[k] && vld[k];
    end
  end
  always @(negedge clock) if (busy) busy_cnt++;
  task automatic send(input logic v, input logic [7:0] d);
    int n = 0;
    pkt_valid = v;
    data_in = d;
    while (busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (busy) bound_fail("send_busy");
    @(negedge clock);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (busy) bound_fail("idle");
  endtask
  task automatic send_pkt(input logic [7:0] hdr, input int npay, input bit bad);
    logic [7:0] p, b;
    int a = int'(hdr[1:0]);
    wait_idle();
    check("err_before_hdr", err, model_err);
    p = hdr;
    if (a != 3) qpush(a, hdr);
    send(1, hdr);
    if (a != 3) check("err_clr_on_hdr", err, 0);
    for (int i = 0; i < npay; i++) begin
      b = 8'($urandom);
      p ^= b;
      if (a != 3) qpush(a, b);
      send(1, b);
    end
    if (bad) p ^= 8'h5a;
    if (a != 3) qpush(a, p);
    send(0, p);
    if (a != 3) model_err = bad;
  endtask
  task automatic drain();
    int n = 0;
    mode = '{1, 1, 1};
    while (vld != 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (vld != 0) bound_fail("drain");
    repeat (2) @(negedge clock);
    mode = '{0, 0, 0};
    @(negedge clock);
    for (int k = 0; k < 3; k++) check($sformatf("drain_q%0d", k), qsize(k), 0);
  endtask
  task automatic reset_dut();
    pkt_valid = 0;
    resetn = 1;
    repeat (2) @(negedge clock);
    resetn = 0;
    model_err = 0;
  endtask
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{8'h00, 0, 0, 0, 3'b001};
    tbl[1] = '{8'h05, 1, 1, 1, 3'b010};
    tbl[2] = '{8'h0a, 3, 0, 0, 3'b100};
    tbl[3] = '{8'hff, 2, 0, 0, 3'b000};
    tbl[4] = '{8'h11, 4, 1, 1, 3'b010};
    tbl[5] = '{8'h13, 0, 0, 1, 3'b000};
    tbl[6] = '{8'h3e, 14, 0, 0, 3'b100};
    tbl[7] = '{8'h34, 13, 1, 1, 3'b001};
    reset_dut();
    check("rst_dout0", data_out_0, 0);
    check("rst_dout1", data_out_1, 0);
    check("rst_dout2", data_out_2, 0);
    check("rst_vld", vld, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    for (int i = 0; i < 8; i++) begin
      send_pkt(tbl[i].hdr, tbl[i].npay, tbl[i].bad);
      wait_idle();
      check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      check($sformatf("tbl%0d_vld", i), vld, tbl[i].exp_vld);
      drain();
    end
    // header 0x39 to FIFO 1 fills it exactly, then one continuous read drains it
    busy_cnt = 0;
    nreads[1] = 0;
    send_pkt(8'h39, 14, 0);
    wait_idle();
    check("s1_busy_cycles", busy_cnt, 2);
    check("s1_vld", vld, 3'b010);
    check("s1_err", err, 0);
    mode[1] = 1;
    for (int n = 0; vld_out_1 && n < 100; n++) @(negedge clock);
    @(negedge clock);
    mode[1] = 0;
    check("s2_nreads", nreads[1], 16);
    check("s2_vld1", vld_out_1, 0);
    check("s2_q1", qsize(1), 0);
    send_pkt(8'h16, 5, 1);
    wait_idle();
    check("s3_err_set", err, 1);
    drain();
    send_pkt(8'h08, 2, 0);
    wait_idle();
    check("s3_err_after", err, 0);
    drain();
    // 20 payload bytes overflow FIFO 0; reads start only once the FSM is stalled
    nreads[0] = 0;
    fork
      send_pkt(8'h50, 20, 0);
      begin
        repeat (24) @(negedge clock);
        check("s4_busy_ffs", busy, 1);
        check("s4_vld_full", vld, 3'b001);
        mode[0] = 1;
      end
    join
    wait_idle();
    drain();
    check("s4_nreads", nreads[0], 22);
    check("s4_err", err, 0);
    fork
      send_pkt(8'h3a, 14, 0);
      begin
        vcnt = 0;
        for (int n = 0; !vld_out_2 && n < 100; n++) @(negedge clock);
        while (vld_out_2 && vcnt < 100) begin
          vcnt++;
          @(negedge clock);
        end
      end
    join
    check("s5_vld_cycles", vcnt, 30);
    check("s5_dout2", data_out_2, 0);
    check("s5_vld2", vld_out_2, 0);
    q2.delete();
    wait_idle();
    busy_cnt = 0;
    send_pkt(8'h43, 4, 0);
    wait_idle();
    check("s6_busy_cycles", busy_cnt, 0);
    check("s6_vld", vld, 0);
    send_pkt(8'h09, 3, 0);
    wait_idle();
    check("s6_route", vld, 3'b010);
    drain();
    // reset in the middle of a packet drops it
    send(1, 8'h04);
    send(1, 8'haa);
    send(1, 8'hbb);
    reset_dut();
    check("mid_rst_vld", vld, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dout0", data_out_0, 0);
    check("mid_rst_err", err, 0);
    mode = '{2, 2, 2};
    for (int i = 0; i < 40; i++)
      send_pkt({6'($urandom_range(63)), 2'($urandom_range(3))}, $urandom_range(25),
               $urandom_range(3) == 0);
    wait_idle();
    check("rand_err", err, model_err);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_1x3.md
Name: router_1x3

Overview:
Single-input, three-output packet router. Byte-serial packets arrive on data_in and are steered by the header's 2-bit address into one of three 16-entry output FIFOs, each read independently by its consumer. An FSM sequences header, payload and parity. It back-pressures the source with busy, checks packet parity (err), and flushes any output FIFO whose data is not read within a timeout.

Parameters:
DATA_WIDTH, 8, byte width of data_in/data_out
FIFO_DEPTH, 16, entries per output FIFO
TIMEOUT, 30, consecutive unread valid cycles before an output FIFO is flushed

Ports:
clock  input  1  system clock; all logic on rising edge
resetn  input  1  synchronous reset, active-high despite the name (1 = reset)
pkt_valid  input  1  high for header and payload bytes; low on the parity byte
data_in  input  8  packet byte stream
read_enb_0  input  1  read request, FIFO 0
read_enb_1  input  1  read request, FIFO 1
read_enb_2  input  1  read request, FIFO 2
data_out_0  output  8  FIFO 0 read data (registered)
data_out_1  output  8  FIFO 1 read data
data_out_2  output  8  FIFO 2 read data
vld_out_0  output  1  FIFO 0 not empty
vld_out_1  output  1  FIFO 1 not empty
vld_out_2  output  1  FIFO 2 not empty
busy  output  1  source must hold data_in/pkt_valid while high
err  output  1  parity mismatch on last packet

Behaviour:
- Packet format: header {len[7:2], addr[1:0]}, then payload bytes while pkt_valid=1, then one parity byte with pkt_valid=0.
- Parity = XOR of header and all payload bytes. len is informational; pkt_valid alone delimits the packet, and len=0 is legal.
- Reset state: state DA, all FIFOs empty, data_out_* = 0, vld_out_* = 0, busy = 0, err = 0, timeout counters = 0.
- A byte is consumed at a rising edge only in a cycle where busy=0.
- busy is a Moore output of the state: 0 in DA, LD and DISCARD; 1 in LFD, FFS, LAF, WTE and CPE.
- State DA:
  - idle while pkt_valid=0.
  - pkt_valid=1 with addr 0..2: latch header and target; clear err. Go to LFD if target FIFO empty, else WTE.
  - addr=3: go to DISCARD.
- State WTE: hold the latched header; go to LFD when target FIFO is empty.
- State LFD: write header to target FIFO; internal parity <= header; go to LD.
- State LD, pkt_valid=1 (payload byte):
  - target not full: write byte, internal parity ^= byte, stay.
  - target full: capture byte in hold register, mark it payload, go to FFS.
- State LD, pkt_valid=0 (parity byte): latch into packet-parity register.
  - target not full: write it, go to CPE.
  - target full: hold it, mark it parity, go to FFS.
- State FFS: wait; go to LAF when target is not full.
- State LAF: write held byte; if payload, parity ^= byte and go to LD; if parity, go to CPE.
- State CPE: err <= (internal parity != packet parity); go to DA. err holds until the next valid header is latched or reset.
- State DISCARD: consume and drop bytes with no FIFO writes; return to DA on the edge that consumes the pkt_valid=0 byte.
- Each FIFO is 16 entries, storing bytes in write order.
  - full = count==16. A write while full is never performed; the FSM prevents it, and a same-cycle read does not enable it.
  - Read: when read_enb_k=1 and FIFO k is not empty, data_out_k <= head entry and the pointer advances. Otherwise data_out_k holds its value.
  - vld_out_k = !empty_k, combinational from count.
  - Simultaneous read and write in one cycle are both performed; count is unchanged.
- Timeout, per FIFO:
  - counter increments each cycle with vld_out_k=1 and read_enb_k=0, and clears otherwise.
  - On reaching TIMEOUT, FIFO k is flushed to empty, data_out_k <= 0, and the counter clears.
  - The FSM is unaffected: a flush of the active target simply frees space.
- Latency: header sampled at edge E0 (DA) and written at E1 (LFD), so vld_out rises after E1. The first payload byte is sampled at E2. Each read returns data one edge after read_enb.
- Synchronous reset mid-packet returns everything to reset values on that edge; the partial packet is lost.

Test Plan:
1. Reset, then send header 0x39 (len 14, addr 1), 14 random payload bytes, and the correct parity byte. Expect: busy high only in LFD and CPE; FIFO 1 holds 16 bytes; vld_out_1=1; err=0; FIFOs 0 and 2 empty.
2. From scenario 1, hold read_enb_1=1. Expect: data_out_1 returns 0x39, then the payload, then parity, in order; vld_out_1 falls after the 16th read.
3. Send a packet to addr 2 with a corrupted parity byte. Expect: err=1 after the CPE edge, cleared when the next valid header is latched.
4. Send a 20-payload-byte packet to addr 0 with no reads, then enable read_enb_0 after busy asserts. Expect: busy high in FFS, no byte lost, all 22 bytes read in order, err=0.
5. Fill FIFO 2 and never read it. Expect: vld_out_2 drops and data_out_2=0 exactly 30 cycles after vld_out_2 rose.
6. Send header 0x43 (addr 3) with payload. Expect: no FIFO writes, busy stays 0, vld_out_* stay 0, and the next valid packet routes normally.
